seg_scan_driver: RTL

- Multiplexed seven-segment display driver for the board's 8-digit, common-anode display.
- Sits directly downstream of the clock divider and consumes its divided output (clkout, typically 100 MHz / 500002 ≈ 200 Hz) as a scan strobe, sampled in the main clk domain.
- Each rising edge of the strobe advances to the next digit.
- A programmable blanking gap is inserted before each digit is driven, to prevent ghosting.
- Displays a 32-bit CPU debug value (PC, register or memory word) as hex, with per-digit enable and decimal point.

---
 rtl/seg_scan_driver_if.sv | 33 +++
 rtl/seg_scan_driver.sv | 118 +++++++++++
 2 files changed

// File: rtl/seg_scan_driver_if.sv
// Display bus for the multiplexed seven-segment scan driver.
// The master supplies strobe and digit content; the slave drives anodes and segments.
interface seg_scan_driver_if #(
  parameter int DIGITS = 8
);
  logic                  scan_clk;
  logic [4*DIGITS-1:0]   data;
  logic [DIGITS-1:0]     digit_en;
  logic [DIGITS-1:0]     dp;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  dot;

  modport master (
    output scan_clk,
    output data,
    output digit_en,
    output dp,
    input  an,
    input  seg,
    input  dot
  );

  modport slave (
    input  scan_clk,
    input  data,
    input  digit_en,
    input  dp,
    output an,
    output seg,
    output dot
  );
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed 7-segment scan driver, common-anode, hex digits.
// Advances one digit per rising strobe edge with an anti-ghosting blank gap.
module seg_scan_driver #(
  parameter int DIGITS       = 8,
  parameter int IDX_W        = 3,
  parameter int BLANK_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  seg_scan_driver_if.slave  bus
);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  localparam logic [7:0] CNT_INIT =
    8'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);

  state_t             state;
  state_t             nstate;
  logic [7:0]         cnt;
  logic [7:0]         ncnt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   nidx;
  logic               s1;
  logic               s2;
  logic               rise;
  logic               run;
  logic               nrun;
  logic [DIGITS-1:0]  nan;
  logic [6:0]         nseg;
  logic               ndot;
  logic [3:0]         nib;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    logic [6:0] s;
    unique case (n)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  assign rise = s1 & ~s2;
  assign nib  = bus.data[4*nidx +: 4];

  // run holds the display dark from reset until the first genuine edge
  always_comb begin
    nstate = state;
    ncnt   = cnt;
    nidx   = idx;
    nrun   = run;
    nan    = '1;
    nseg   = '1;
    ndot   = 1'b1;
    if (rise) begin
      nrun = 1'b1;
      nidx = (idx == LAST) ? '0 : idx + IDX_W'(1);
      if (HAS_BLANK) begin
        nstate = BLANK;
        ncnt   = CNT_INIT;
      end else begin
        nstate = DRIVE;
      end
    end else if (state == BLANK && run) begin
      if (cnt == 8'd0) nstate = DRIVE;
      else             ncnt   = cnt - 8'd1;
    end
    if (nstate == DRIVE && bus.digit_en[nidx]) begin
      nan  = ~(DIGITS'(1) << nidx);
      nseg = hex7(nib);
      ndot = ~bus.dp[nidx];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1      <= 1'b1;
      s2      <= 1'b1;
      idx     <= LAST;
      state   <= BLANK;
      cnt     <= 8'd0;
      run     <= 1'b0;
      bus.an  <= '1;
      bus.seg <= 7'b1111111;
      bus.dot <= 1'b1;
    end else begin
      s1      <= bus.scan_clk;
      s2      <= s1;
      idx     <= nidx;
      state   <= nstate;
      cnt     <= ncnt;
      run     <= nrun;
      bus.an  <= nan;
      bus.seg <= nseg;
      bus.dot <= ndot;
    end
  end

endmodule
